// File: rtl/mux2_rr_arbiter_pkg.sv
// Shared types and constants for the two-requester round-robin arbiter.
package mux2_rr_arbiter_pkg;

   typedef enum logic [1:0] {IDLE, HOLD_A, HOLD_B} arb_state_e;

   localparam logic SRC_A = 1'b0;
   localparam logic SRC_B = 1'b1;

endpackage

// File: rtl/mux2_rr_arbiter_if.sv
// Handshake bundle between requesters A/B, the arbiter and the downstream sink.
// MUX2_ARB_LOCK_EN adds the a_lock/b_lock burst-lock inputs.
interface mux2_rr_arbiter_if #(parameter int unsigned N = 4);

   logic [N-1:0] a_data;
   logic         a_valid;
   logic         a_ready;
   logic [N-1:0] b_data;
   logic         b_valid;
   logic         b_ready;
   logic [N-1:0] out_data;
   logic         out_valid;
   logic         out_ready;
   logic         out_src;
`ifdef MUX2_ARB_LOCK_EN
   logic         a_lock;
   logic         b_lock;

   modport slave (
      input  a_data, a_valid, a_lock, b_data, b_valid, b_lock, out_ready,
      output a_ready, b_ready, out_data, out_valid, out_src
   );
   modport master (
      output a_data, a_valid, a_lock, b_data, b_valid, b_lock, out_ready,
      input  a_ready, b_ready, out_data, out_valid, out_src
   );
`else
   modport slave (
      input  a_data, a_valid, b_data, b_valid, out_ready,
      output a_ready, b_ready, out_data, out_valid, out_src
   );
   modport master (
      output a_data, a_valid, b_data, b_valid, out_ready,
      input  a_ready, b_ready, out_data, out_valid, out_src
   );
`endif

endinterface

// File: rtl/mux2_rr_arbiter_mux2_1.sv
// Plain N-bit 2:1 multiplexer used for payload selection.
module mux2_1 #(
   parameter int unsigned N = 4
) (
   input  logic [N-1:0] d0_i,
   input  logic [N-1:0] d1_i,
   input  logic         sel_i,
   output logic [N-1:0] y_o
);

   assign y_o = sel_i ? d1_i : d0_i;

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter sharing one registered output slot between requesters A and B.
// Optional burst lock is compiled in with MUX2_ARB_LOCK_EN.
module mux2_rr_arbiter
   import mux2_rr_arbiter_pkg::*;
#(
   parameter int unsigned N = 4
) (
   input logic               clk,
   input logic               rst,
   mux2_rr_arbiter_if.slave  bus
);

   arb_state_e   state_q;
   logic         last_q;
   logic [N-1:0] data_q;
   logic [N-1:0] mux_y;
   logic         free;
   logic         win_b;
   logic         grant_a;
   logic         grant_b;
`ifdef MUX2_ARB_LOCK_EN
   logic         lock_q;
   logic         owner_valid;
`endif

   always_comb begin
      free    = (state_q == IDLE) | bus.out_ready;
      win_b   = (last_q == SRC_A);
      grant_a = 1'b0;
      grant_b = 1'b0;
`ifdef MUX2_ARB_LOCK_EN
      owner_valid = (last_q == SRC_B) ? bus.b_valid : bus.a_valid;
      // A held lock keeps the previous winner on top while it stays valid.
      if (lock_q) win_b = (last_q == SRC_B);
`endif
      if (free && !rst) begin
         if (bus.a_valid && bus.b_valid) begin
            grant_b = win_b;
            grant_a = !win_b;
         end else begin
            grant_a = bus.a_valid;
            grant_b = bus.b_valid;
         end
      end
   end

   mux2_1 #(.N(N)) u_mux (
      .d0_i  (bus.a_data),
      .d1_i  (bus.b_data),
      .sel_i (grant_b),
      .y_o   (mux_y)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         data_q  <= '0;
         last_q  <= SRC_B;
`ifdef MUX2_ARB_LOCK_EN
         lock_q  <= 1'b0;
`endif
      end else begin
         if (grant_a || grant_b) begin
            state_q <= grant_b ? HOLD_B : HOLD_A;
            data_q  <= mux_y;
            last_q  <= grant_b ? SRC_B : SRC_A;
         end else if (free) begin
            state_q <= IDLE;
         end
`ifdef MUX2_ARB_LOCK_EN
         if (grant_a || grant_b) begin
            lock_q <= grant_b ? bus.b_lock : bus.a_lock;
         end else if (!owner_valid) begin
            lock_q <= 1'b0;
         end
`endif
      end
   end

   assign bus.a_ready   = grant_a;
   assign bus.b_ready   = grant_b;
   assign bus.out_data  = data_q;
   assign bus.out_valid = (state_q != IDLE);
   assign bus.out_src   = (state_q == HOLD_B);

endmodule

// File: doc/mux2_rr_arbiter.md
Name: mux2_rr_arbiter

Overview:
- Round-robin arbiter that shares one N-bit downstream channel between two valid/ready requesters, A and B.
- Drives the select of an internal 2:1 mux and registers the chosen word into a single-entry output slot.
- Sits in front of any shared P02 datapath resource (ALU, memory port, UART TX) that two producers must time-share.
- Guarantees no starvation and no data loss under downstream back-pressure.

Parameters:
- N, 4, data width of each requester and of the output.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- a_data  input  N  requester A payload.
- a_valid  input  1  requester A has data.
- a_ready  output  1  A's word is accepted this cycle (a_valid & a_ready = transfer).
- b_data  input  N  requester B payload.
- b_valid  input  1  requester B has data.
- b_ready  output  1  B's word is accepted this cycle.
- out_data  output  N  registered winning payload.
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_src  output  1  source of out_data: 0 = A, 1 = B.

Behaviour:
- Reset (sync, rst=1 at a clk edge):
  - out_valid=0, out_data=0, out_src=0, state=IDLE, last=1 (B), so A wins the first tie.
  - Any word held in the slot is discarded.
  - While rst is high, a_ready=b_ready=0.
- Slot free condition: free = !out_valid | out_ready.
- Arbitration (combinational, evaluated only when free):
  - Both valid: grant the side != last.
  - One valid: grant that side.
  - Neither valid: no grant.
- Ready outputs:
  - a_ready = free & grant_a; b_ready = free & grant_b.
  - At most one ready is high in any cycle.
  - Ready never depends on the same requester's data; it may depend on its valid.
- Transfer (grant side X at edge):
  - out_data <= X_data via the mux; out_valid <= 1; out_src <= X; last <= X.
  - Latency: 1 cycle from accepted input to out_valid.
- Consume without a new grant (out_ready & out_valid, no grant): out_valid <= 0; out_data is held.
- Stall (out_valid & !out_ready): out_data, out_src and out_valid hold; both readys are 0.
- Full throughput: with out_ready=1 continuously, one word is accepted and one presented every cycle.
- State machine (state = contents of the output slot):
  - IDLE (slot empty): grant A -> HOLD_A; grant B -> HOLD_B; else stay IDLE.
  - HOLD_A: !out_ready -> stay. out_ready with grant A -> HOLD_A; with grant B -> HOLD_B; with no grant -> IDLE.
  - HOLD_B: symmetric to HOLD_A.
  - out_valid = (state != IDLE); out_src = (state == HOLD_B).
- Fairness: with both requesters continuously valid, grants alternate A,B,A,B. Maximum wait is 1 grant.
- Requester rule, checked by an assertion in the bench: once X_valid is high it stays high with stable data until X_ready.

Optional Feature:
- Macro: MUX2_ARB_LOCK_EN.
- Defined:
  - Adds input ports a_lock and b_lock (1 bit each).
  - If the last transfer came from X with X_lock=1, and X is still valid at the next arbitration, X wins even if the other side is valid. This allows burst transfers.
  - The lock releases when X_lock=0 at a transfer, or when X_valid drops.
  - last updates normally, so the other side wins the first tie after release.
- Not defined: the lock ports do not exist and arbitration is pure round-robin as above.

Decomposition:
- Pkg_Global gains:
  - typedef enum logic [1:0] {IDLE, HOLD_A, HOLD_B} arb_state_e;
  - localparams SRC_A=1'b0 and SRC_B=1'b1.
- Sub-module: instantiate the existing mux2_1 (#(.N(N))) for payload selection, with selector = grant_b.
- The FSM, arbitration logic and output register live in mux2_rr_arbiter.

Test Plan:
- Reset: rst=1 for 2 cycles with a_valid=b_valid=1 -> a_ready=b_ready=0, out_valid=0, out_data=0. First grant after release goes to A.
- Single requester: N=8, a_data=8'h3C, a_valid=1 for 1 cycle, out_ready=1 -> a_ready=1 in cycle 0; next cycle out_valid=1, out_data=8'h3C, out_src=0; then out_valid=0.
- Contention: both valid continuously, A sends 8'h01..8'h04, B sends 8'hA1..8'hA4, out_ready=1 -> output sequence 01,A1,02,A2,03,A3,04,A4 with one word per cycle.
- Back-pressure: slot holds 8'h55 from B and out_ready=0 for 5 cycles -> out_data stays 8'h55 with out_src=1, both readys 0. When out_ready=1, A is granted in that same cycle.
- Mid-operation reset: rst=1 while in HOLD_A -> next cycle out_valid=0 and state IDLE. The pending word is not re-presented.
- MUX2_ARB_LOCK_EN: a_lock=1 for 3 A words with B continuously valid -> output A,A,A, then B. The same stimulus with the macro undefined gives A,B,A,B,A.
